// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one big-endian byte/half/word access at a time against a word memory.
// Optional LSU_RMW_EN enables sub-word stores via read-modify-write; otherwise they return an error.
module mem_access_unit #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        memread,
    output logic        memwrite,
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

`ifdef LSU_RMW_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RESP   = 3'd3,
        S_RMW_RD = 3'd4,
        S_RMW_WR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RESP   = 3'd3
    } state_t;
`endif

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;
    logic        memread_q;
    logic        memwrite_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
`ifdef LSU_RMW_EN
    logic [31:0] wdata_q;
`endif

    logic misaligned;
    assign misaligned = (req_size == 2'd3)
                     || ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // Big-endian lane select: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LSU_RMW_EN
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        if (size == 2'd0) begin
            case (off)
                2'd0:    r = {wd[7:0], word[23:0]};
                2'd1:    r = {word[31:24], wd[7:0], word[15:0]};
                2'd2:    r = {word[31:16], wd[7:0], word[7:0]};
                default: r = {word[31:8], wd[7:0]};
            endcase
        end else if (size == 2'd1) begin
            r = off[1] ? {word[31:16], wd[15:0]} : {wd[15:0], word[15:0]};
        end else begin
            r = wd;
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            off_q            <= 2'd0;
            size_q           <= 2'd0;
            signed_q         <= 1'b0;
            mem_address_q    <= 32'd0;
            mem_write_data_q <= 32'd0;
            memread_q        <= 1'b0;
            memwrite_q       <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'd0;
            resp_err_q       <= 1'b0;
`ifdef LSU_RMW_EN
            wdata_q          <= 32'd0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q         <= req_addr[1:0];
                        size_q        <= req_size;
                        signed_q      <= req_signed;
                        mem_address_q <= {req_addr[31:2], 2'b00};
`ifdef LSU_RMW_EN
                        wdata_q       <= req_wdata;
`endif
                        if (misaligned) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!req_write) begin
                            state_q   <= S_RD;
                            memread_q <= 1'b1;
                            cnt_q     <= RD_CNT;
                        end else if (req_size == 2'd2) begin
                            state_q          <= S_WR;
                            memwrite_q       <= 1'b1;
                            mem_write_data_q <= req_wdata;
                            cnt_q            <= WR_CNT;
                        end else begin
`ifdef LSU_RMW_EN
                            state_q   <= S_RMW_RD;
                            memread_q <= 1'b1;
                            cnt_q     <= RD_CNT;
`else
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
`endif
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        memread_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_extract(mem_read_data, size_q, signed_q, off_q);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WR: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        memwrite_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`ifdef LSU_RMW_EN
                S_RMW_RD: begin
                    if (cnt_q == 4'd0) begin
                        state_q          <= S_RMW_WR;
                        memread_q        <= 1'b0;
                        memwrite_q       <= 1'b1;
                        mem_write_data_q <= store_merge(mem_read_data, wdata_q, size_q, off_q);
                        cnt_q            <= WR_CNT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RMW_WR: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        memwrite_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`endif
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    memread_q  <= 1'b0;
                    memwrite_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready is gated by reset so upstream never sees the unit as available while it is held.
    assign req_ready      = (state_q == S_IDLE) && !reset;
    assign stall          = ~req_ready;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign memread        = memread_q;
    assign memwrite       = memwrite_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model feeds a scoreboard checked on each response.
// Expectations follow LSU_RMW_EN when it is defined for the build.
module tb_mem_access_unit;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 2;
`ifdef LSU_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        memread;
    logic        memwrite;
    logic [31:0] mem_read_data;

    mem_access_unit #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .memread(memread), .memwrite(memwrite), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory the DUT talks to (16 words) and an independent byte-level reference.
    logic [31:0] env_mem [0:15];
    logic [7:0]  ref_b   [0:63];
    assign mem_read_data = env_mem[mem_address[5:2]];
    always @(posedge clk) if (memwrite) env_mem[mem_address[5:2]] <= mem_write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t_acc;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] addr;
        logic [31:0] wword;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        else n_pass++;
    endtask

    // Response monitor
    int rd_n = 0, wr_n = 0, ov_n = 0;
    logic [31:0] last_addr = 32'd0, last_wd = 32'd0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_n = 0; wr_n = 0; ov_n = 0;
        end else begin
            if (memread)  begin rd_n++; last_addr = mem_address; end
            if (memwrite) begin wr_n++; last_addr = mem_address; last_wd = mem_write_data; end
            if (memread && memwrite) ov_n++;
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("rdata",     resp_rdata, e.rdata);
                    check("err",       32'(resp_err), 32'(e.err));
                    check("latency",   32'(cyc - e.t_acc), 32'(e.lat));
                    check("rd_cycles", 32'(rd_n), 32'(e.rd));
                    check("wr_cycles", 32'(wr_n), 32'(e.wr));
                    check("overlap",   32'(ov_n), 32'd0);
                    if (e.rd + e.wr > 0) check("mem_addr", last_addr, e.addr);
                    if (e.wr > 0)        check("wdata",    last_wd,   e.wword);
                end
                rd_n = 0; wr_n = 0; ov_n = 0;
            end
        end
    end

    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int nb;
        int base;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a[5:0]);
        e.rdata = 32'd0; e.rd = 0; e.wr = 0; e.wword = 32'd0;
        e.addr  = {a[31:2], 2'b00};
        e.err   = (sz == 2'd3) || ((base % nb) != 0) || (wr && nb != 4 && !RMW);
        e.lat   = 1;
        if (!e.err) begin
            if (!wr) begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_b[base + i]);
                if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                e.rdata = v;
                e.rd    = RD_LAT;
                e.lat   = 1 + RD_LAT;
            end else begin
                for (int i = 0; i < nb; i++) ref_b[base + i] = 8'(wd >> (8*(nb-1-i)));
                for (int i = 0; i < 4; i++) e.wword = (e.wword << 8) | 32'(ref_b[(base & ~3) + i]);
                e.wr  = WR_LAT;
                e.rd  = (nb == 4) ? 0 : RD_LAT;
                e.lat = 1 + e.rd + WR_LAT;
            end
        end
        return e;
    endfunction

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold);
        exp_t e;
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            e = model(wr, sz, sg, a, wd);
            e.t_acc = cyc;
            sb_q.push_back(e);
            @(posedge clk);
            if (!hold) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 16; i++) env_mem[i] = 32'h0101_0101 * 32'(i) ^ 32'hA5C3_0000;
        env_mem[2] = 32'h1122_3344;
        env_mem[3] = 32'h80FF_7F01;
        for (int i = 0; i < 16; i++) begin
            w = env_mem[i];
            for (int j = 0; j < 4; j++) ref_b[4*i + j] = 8'(w >> (24 - 8*j));
        end

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready",    32'(req_ready),  32'd0);
        check("rst_stall",    32'(stall),      32'd1);
        check("rst_memread",  32'(memread),    32'd0);
        check("rst_memwrite", 32'(memwrite),   32'd0);
        check("rst_resp",     32'(resp_valid), 32'd0);
        check("rst_addr",     mem_address,     32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        do_req(1'b0, 2'd0, 1'b1, 32'h0C, 32'd0, 1'b0);          // lb  -> FFFFFF80
        do_req(1'b0, 2'd0, 1'b0, 32'h0C, 32'd0, 1'b0);          // lbu -> 00000080
        do_req(1'b0, 2'd1, 1'b0, 32'h0E, 32'd0, 1'b0);          // lhu -> 00007F01
        do_req(1'b0, 2'd1, 1'b1, 32'h0C, 32'd0, 1'b0);          // lh  -> FFFF80FF
        do_req(1'b0, 2'd0, 1'b1, 32'h0D, 32'd0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0F, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 1'b0);          // lw  -> 11223344
        do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AB, 1'b0);  // sb
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'h1234_BEEF, 1'b0);  // sh
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 1'b0);          // misaligned lw
        do_req(1'b0, 2'd1, 1'b1, 32'h0D, 32'd0, 1'b0);          // misaligned lh
        do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, 1'b0);          // illegal size
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b1);  // sw then lw, req_valid held
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
        drain();

        for (int k = 0; k < 24; k++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 35)), $urandom, 1'b0);
        end
        drain();

        // Abort a word store mid-phase with reset: no response may follow.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h24; req_wdata = 32'h5555_AAAA;
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_memwrite_on", 32'(memwrite), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_memwrite_off", 32'(memwrite), 32'd0);
        check("abort_ready_rst",    32'(req_ready), 32'd0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        check("abort_ready_after", 32'(req_ready), 32'd1);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
